// File: rtl/keypad_if.sv
// keypad_if: keypad pins plus the debounced key outputs bundled as one port.
//   row        keypad rows, active-low, asynchronous to clk (pins -> scanner)
//   col        keypad columns, one-hot active-low drive       (scanner -> pins)
//   decode     debounced key code, 0 = no key                 (scanner -> FSM)
//   key_valid  high while decode != 0                         (scanner -> FSM)
//   key_pulse  one-cycle strobe on a new nonzero code         (scanner -> FSM)
// The scanner takes the slave modport; the board/FSM side takes master.
interface keypad_if;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] decode;
  logic       key_valid;
  logic       key_pulse;

  modport master (output row, input col, decode, key_valid, key_pulse);
  modport slave  (input row, output col, decode, key_valid, key_pulse);
endinterface

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low keypad, debounces whole frames and
// presents a stable 4-bit key code (0 = no key) to the game FSM.
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   kp     keypad_if.slave: row in, col/decode/key_valid/key_pulse out
// Each column is driven for SCAN_DIV cycles; four columns form one frame.
// A frame yields a code only when exactly one usable key is seen, and that
// code must repeat for DEBOUNCE_CNT frames before it reaches decode.
module keypad_scanner #(
  parameter int SCAN_DIV     = 4,
  parameter int DEBOUNCE_CNT = 3
) (
  input  logic     clk,
  input  logic     rst_n,
  keypad_if.slave  kp
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CNT);

  logic [3:0]       row_meta_q, row_sync_q;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       col_idx_q, col_idx_d;
  // Keys seen so far in the frame: 0, 1 or 2 (2 means "two or more").
  logic [1:0]       acc_hits_q, acc_hits_d;
  logic [3:0]       acc_code_q, acc_code_d;
  logic [3:0]       cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       decode_q, decode_d;
  logic             pulse_q, pulse_d;

  logic       slot_end, frame_end;
  logic [1:0] col_hits;
  logic [3:0] col_code;
  logic [2:0] hits_sum;
  logic [1:0] hits_sat;
  logic [3:0] merged_code;
  logic [3:0] frame_result;

  assign slot_end  = (div_q == DIV_LAST);
  assign frame_end = slot_end && (col_idx_q == 2'd3);

  // Keys visible in the current column; key (3,3) has no code and is skipped.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    col_hits = 2'd0;
    col_code = 4'd0;
    for (int r = 0; r < 4; r++) begin
      if (!row_sync_q[r] && !(col_idx_q == 2'd3 && r == 3)) begin
        if (col_hits != 2'd2) col_hits = col_hits + 2'd1;
        col_code = {col_idx_q, 2'(r)} + 4'd1;
      end
    end
  end

  always_comb begin
    hits_sum     = {1'b0, acc_hits_q} + {1'b0, col_hits};
    hits_sat     = (hits_sum >= 3'd2) ? 2'd2 : hits_sum[1:0];
    merged_code  = (col_hits != 2'd0) ? col_code : acc_code_q;
    frame_result = (hits_sat == 2'd1) ? merged_code : 4'd0;
  end

  always_comb begin
    div_d      = div_q;
    col_idx_d  = col_idx_q;
    acc_hits_d = acc_hits_q;
    acc_code_d = acc_code_q;
    cand_d     = cand_q;
    cnt_d      = cnt_q;
    decode_d   = decode_q;
    pulse_d    = 1'b0;

    if (slot_end) begin
      div_d     = '0;
      col_idx_d = col_idx_q + 2'd1;
      if (frame_end) begin
        acc_hits_d = 2'd0;
        acc_code_d = 4'd0;
        if (frame_result == cand_q) begin
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        end else begin
          cand_d = frame_result;
          cnt_d  = CNT_W'(1);
        end
      end else begin
        acc_hits_d = hits_sat;
        acc_code_d = merged_code;
      end
    end else begin
      div_d = div_q + 1'b1;
    end

    // Accepted candidate reaches decode one cycle after the deciding frame.
    if (cnt_q == CNT_MAX && cand_q != decode_q) begin
      decode_d = cand_q;
      pulse_d  = (cand_q != 4'd0);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta_q <= 4'hF;
      row_sync_q <= 4'hF;
      div_q      <= '0;
      col_idx_q  <= 2'd0;
      acc_hits_q <= 2'd0;
      acc_code_q <= 4'd0;
      cand_q     <= 4'd0;
      cnt_q      <= '0;
      decode_q   <= 4'd0;
      pulse_q    <= 1'b0;
    end else begin
      row_meta_q <= kp.row;
      row_sync_q <= row_meta_q;
      div_q      <= div_d;
      col_idx_q  <= col_idx_d;
      acc_hits_q <= acc_hits_d;
      acc_code_q <= acc_code_d;
      cand_q     <= cand_d;
      cnt_q      <= cnt_d;
      decode_q   <= decode_d;
      pulse_q    <= pulse_d;
    end
  end

  assign kp.col       = ~(4'b0001 << col_idx_q);
  assign kp.decode    = decode_q;
  assign kp.key_valid = (decode_q != 4'd0);
  assign kp.key_pulse = pulse_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: drives a behavioural 4x4 keypad (row[r]=0 iff column c
// is driven low and key (r,c) is held) and compares the scanner outputs with
// a key-set model: exactly one usable key -> 4*c+r+1, otherwise 0, settled
// within the latency bound, one pulse per new nonzero code.
module tb_keypad_scanner;

  localparam int LAT = 67;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] held = 16'h0;   // bit index 4*c + r
  logic [3:0]  row_drv;
  logic [3:0]  model_decode = 4'd0;
  int          pulse_cnt = 0;
  int          n_vec = 0;
  int          n_err = 0;

  keypad_if kp_if ();

  keypad_scanner dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kp    (kp_if)
  );

  always #5 clk = ~clk;

  always_comb begin
    row_drv = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (held[4*c + r] && !kp_if.col[c]) row_drv[r] = 1'b0;
  end
  assign kp_if.row = row_drv;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] ref_code(input logic [15:0] keys);
    int n = 0;
    logic [3:0] code = 4'd0;
    for (int i = 0; i < 15; i++)
      if (keys[i]) begin
        n++;
        code = 4'(i + 1);
      end
    return (n == 1) ? code : 4'd0;
  endfunction

  // Pulse counter and key_valid consistency, sampled 1 ns after each edge.
  always @(posedge clk) begin
    #1;
    if (kp_if.key_pulse === 1'b1) pulse_cnt++;
    check("key_valid", {31'd0, kp_if.key_valid}, {31'd0, kp_if.decode != 4'd0});
  end

  // Apply a key set, check the settled code, its stability and the pulse count.
  task automatic apply(input logic [15:0] keys, input int hold, input string tag);
    int p0;
    logic [3:0] exp;
    int exp_p;
    @(negedge clk);
    held  = keys;
    p0    = pulse_cnt;
    exp   = ref_code(keys);
    exp_p = (exp != 4'd0 && exp != model_decode) ? 1 : 0;
    repeat (LAT) @(posedge clk);
    #2;
    check({tag, "_settle"}, {28'd0, kp_if.decode}, {28'd0, exp});
    repeat (hold - LAT) @(posedge clk);
    #2;
    check({tag, "_hold"}, {28'd0, kp_if.decode}, {28'd0, exp});
    check({tag, "_pulses"}, pulse_cnt - p0, exp_p);
    model_decode = exp;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p0;
    logic [15:0] keys;
    int kind, a, b;

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_col",   {28'd0, kp_if.col},    32'hE);
    check("rst_decode",{28'd0, kp_if.decode}, 32'h0);
    check("rst_valid", {31'd0, kp_if.key_valid}, 32'h0);
    check("rst_pulse", {31'd0, kp_if.key_pulse}, 32'h0);
    rst_n = 1'b1;

    // Column rotation: each column held for 4 cycles.
    for (int n = 1; n <= 16; n++) begin
      @(posedge clk);
      #2;
      check("col_rot", {28'd0, kp_if.col}, {28'd0, ~(4'b0001 << ((n / 4) % 4))});
    end

    apply(16'h0010, 200, "hold_0_1");          // (0,1) -> 5
    apply(16'h0000, 120, "release_0_1");

    // Bounce (2,0): toggle every 24 cycles for 480 cycles.
    p0 = pulse_cnt;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      held = (i % 2 == 0) ? 16'h0004 : 16'h0000;
      repeat (23) @(negedge clk);
      check("bounce_decode", {28'd0, kp_if.decode}, 32'h0);
    end
    check("bounce_pulses", pulse_cnt - p0, 0);
    apply(16'h0004, 150, "hold_2_0");          // -> 3
    apply(16'h0000, 100, "release_2_0");

    apply(16'h0201, 150, "multi");             // (0,0)+(1,2) -> 0
    apply(16'h0001, 150, "multi_rel");         // -> 1
    apply(16'h0000, 100, "release_0_0");
    apply(16'h0800, 150, "hold_3_2");          // -> 12
    apply(16'h1000, 150, "slide_0_3");         // -> 13
    apply(16'h8000, 150, "only_3_3");          // -> 0
    apply(16'h0000, 100, "release_3_3");

    // Reset while (1,0) is held.
    apply(16'h0002, 150, "hold_1_0");          // -> 2
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_decode", {28'd0, kp_if.decode}, 32'h0);
    check("midrst_valid",  {31'd0, kp_if.key_valid}, 32'h0);
    check("midrst_col",    {28'd0, kp_if.col}, 32'hE);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_decode = 4'd0;
    apply(16'h0002, 150, "rehold_1_0");
    apply(16'h0000, 100, "release_1_0");

    // Randomized key sets.
    for (int s = 0; s < 24; s++) begin
      kind = $urandom_range(0, 3);
      a = $urandom_range(0, 15);
      b = $urandom_range(0, 15);
      keys = 16'h0;
      if (kind == 1 || kind == 2) keys[a] = 1'b1;
      if (kind == 3) begin
        keys[a] = 1'b1;
        keys[b] = 1'b1;
      end
      apply(keys, $urandom_range(80, 200), "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
